// File: rtl/cic_pkg.sv
// cic_pkg: shared CIC constants and bit-growth helper
package cic_pkg;
    localparam int N = 3;
    localparam int R = 8;
    localparam int M = 1;
    localparam int CNT_W = 3;
    function automatic int cic_width(input int nin);
        return nin + N * $clog2(R);
    endfunction
endpackage

// File: rtl/cic_integrator.sv
// cic_integrator: one enabled modulo-2^W accumulator with synchronous active-high reset
module cic_integrator
    import cic_pkg::*;
#(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [W-1:0] a,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        if (rstn) q <= '0;
        else if (en) q <= q + a;
endmodule

// File: rtl/cic.sv
// cic: 3-stage CIC decimator, R=8, M=1; rstn is active-high despite its name.
// CIC_OUT_ROUND_EN selects round-half-up with saturation instead of MSB truncation.
module cic
    import cic_pkg::*;
#(
    parameter int NIN  = 12,
    parameter int NMAX = 21,
    parameter int NOUT = 21
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic [NIN-1:0]  din,
    output logic            valid,
    output logic [NOUT-1:0] dout
);
    logic [NMAX-1:0] din_ext, i1, i2, i3, d0, d1, d2, c1, c2, c3;
    logic [NOUT-1:0] q;
    logic [CNT_W-1:0] cnt;
    logic stb;
    assign din_ext = {{(NMAX-NIN){din[NIN-1]}}, din};
    // each stage adds the previous stage's pre-edge value, forming a pipelined chain
    cic_integrator #(.W(NMAX)) u_i1 (.clk(clk), .rstn(rstn), .en(en), .a(din_ext), .q(i1));
    cic_integrator #(.W(NMAX)) u_i2 (.clk(clk), .rstn(rstn), .en(en), .a(i1), .q(i2));
    cic_integrator #(.W(NMAX)) u_i3 (.clk(clk), .rstn(rstn), .en(en), .a(i2), .q(i3));
    assign stb = en && cnt == CNT_W'(R - 1);
    assign c1 = i3 - d0;
    assign c2 = c1 - d1;
    assign c3 = c2 - d2;
`ifdef CIC_OUT_ROUND_EN
    generate
        if (NOUT < NMAX) begin : g_rnd
            logic [NMAX-1:0] s;
            assign s = c3 + (NMAX'(1) << (NMAX - NOUT - 1));
            // a positive value that turns negative has overflowed: clamp to max positive
            assign q = (!c3[NMAX-1] && s[NMAX-1]) ? {1'b0, {(NOUT-1){1'b1}}} : s[NMAX-1 -: NOUT];
        end else begin : g_trn
            assign q = c3[NMAX-1 -: NOUT];
        end
    endgenerate
`else
    assign q = c3[NMAX-1 -: NOUT];
`endif
    always_ff @(posedge clk)
        if (rstn) begin
            cnt   <= '0;
            d0    <= '0;
            d1    <= '0;
            d2    <= '0;
            dout  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= stb;
            if (en) cnt <= cnt + CNT_W'(1);
            if (stb) begin
                d0   <= i3;
                d1   <= c1;
                d2   <= c2;
                dout <= q;
            end
        end
endmodule

// File: tb/tb_cic.sv
// tb_cic: directed bench for cic, golden model is the direct 22-tap boxcar^3 convolution
module tb_cic;
    localparam int NIN  = 12;
    localparam int NMAX = 21;
    localparam int NOUT = 21;

    logic            clk = 1'b0;
    logic            rstn;
    logic            en;
    logic [NIN-1:0]  din;
    logic            valid;
    logic [NOUT-1:0] dout;

    int nvec = 0;
    int nerr = 0;
    int nvalid = 0;
    int h[22];
    int hist[$];
    int tone[200];
    logic            exp_v = 1'b0;
    logic [NOUT-1:0] exp_d = '0;

    cic #(.NIN(NIN), .NMAX(NMAX), .NOUT(NOUT)) dut (
        .clk(clk), .rstn(rstn), .en(en), .din(din), .valid(valid), .dout(dout)
    );

    always #5 clk = ~clk;

    // output p sees enabled samples x[8p+4-j] through h[j] (two-sample integrator latency)
    function automatic int model();
        int s = 0;
        int base = hist.size() - 4;
        for (int j = 0; j < 22; j++)
            if (base - j >= 0) s += h[j] * hist[base - j];
        return s;
    endfunction

    task automatic chk(input string tag, input logic [NOUT-1:0] got, input logic [NOUT-1:0] want);
        nvec++;
        assert (got === want) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step(input logic e, input logic [NIN-1:0] d);
        en = e;
        din = d;
        @(posedge clk);
        #1;
        if (rstn) begin
            hist.delete();
            exp_v = 1'b0;
            exp_d = '0;
        end else if (e) begin
            hist.push_back(int'($signed(d)));
            exp_v = (hist.size() % 8) == 0;
            if (exp_v) exp_d = NOUT'(model());
        end else begin
            exp_v = 1'b0;
        end
        if (valid === 1'b1) nvalid++;
        chk("valid", NOUT'(valid), NOUT'(exp_v));
        chk("dout", dout, exp_d);
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b1;
        for (int k = 0; k < n; k++) step(1'b1, 12'h155);
        rstn = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < 8; c++)
                    h[a + b + c] += 1;
        for (int n = 0; n < 200; n++)
            tone[n] = int'(2047.0 * $cos(2.0 * 3.14159265358979 * 0.15 * n));
        rstn = 1'b1;
        en = 1'b0;
        din = '0;

        do_reset(3);
        chk("reset_valid", NOUT'(valid), '0);
        chk("reset_dout", dout, '0);
        nvalid = 0;
        for (int k = 0; k < 7; k++) step(1'b1, 12'd1);
        chk("no_early_valid", NOUT'(nvalid), '0);
        step(1'b1, 12'd1);
        chk("first_valid_at_8", NOUT'(valid), NOUT'(1));
        for (int k = 0; k < 56; k++) step(1'b1, 12'd1);
        chk("dc_small", dout, 21'h000200);
        chk("dc_small_count", NOUT'(nvalid), NOUT'(8));

        do_reset(2);
        for (int k = 0; k < 64; k++) step(1'b1, 12'h7FF);
        chk("dc_pos_fs", dout, 21'h0FFE00);

        do_reset(2);
        for (int k = 0; k < 64; k++) step(1'b1, 12'h800);
        chk("dc_neg_fs", dout, 21'h100000);

        do_reset(2);
        nvalid = 0;
        for (int k = 0; k < 128; k++) step(k % 2 == 0, 12'd1);
        chk("gated_dc", dout, 21'h000200);
        chk("gated_count", NOUT'(nvalid), NOUT'(8));

        do_reset(2);
        nvalid = 0;
        for (int k = 0; k < 2000; k++) step(1'b1, NIN'(tone[k % 200]));
        chk("tone_count", NOUT'(nvalid), NOUT'(250));
        do_reset(2);
        chk("midrun_reset_dout", dout, '0);
        for (int k = 0; k < 200; k++) step(1'b1, NIN'(tone[k % 200]));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/cic.md
Name: cic

Overview:
- Three-stage cascaded integrator-comb (CIC) decimation filter with decimation ratio 8 and differential delay 1.
- Sits after an ADC / NCO mixer in the receive chain. Takes signed NIN-bit samples at the clk rate, qualified by en.
- Produces signed NOUT-bit samples at 1/8 of the enabled-sample rate, each flagged by a one-cycle valid pulse.

Parameters:
- NIN, 12: input sample width, signed two's complement.
- NMAX, 21: internal integrator/comb width. Must be at least NIN + N·log2(R) = 12 + 9.
- NOUT, 21: output width; NOUT ≤ NMAX. dout carries the NOUT MSBs of the NMAX-bit comb result.
- Fixed localparams: N = 3 (stages), R = 8 (decimation), M = 1 (differential delay).

Ports:
- clk, input, 1: sole clock; every register updates on its rising edge.
- rstn, input, 1: synchronous, active-high reset, sampled on the clk rising edge. The port keeps the codebase name rstn, but asserted = 1.
- en, input, 1: input-sample qualifier; din is consumed on each clk edge where en=1.
- din, input, NIN: signed input sample.
- valid, output, 1: one-cycle strobe marking a new dout.
- dout, output, NOUT: signed decimated output, held between strobes.

Behaviour:
- Reset (rstn=1 at the edge): all integrator, comb-delay and counter registers clear to 0; dout=0; valid=0. Reset mid-operation discards all history; the next output needs 8 fresh enabled samples.
- din is sign-extended to NMAX bits.
- Integrator stages:
  - When en=1: i1 <= i1 + din_ext; i2 <= i2 + i1; i3 <= i3 + i2. Each stage uses the register values from before the edge, forming a pipelined chain.
  - All arithmetic is modulo 2^NMAX. Wrap-around is intentional and is cancelled by the combs.
- When en=0: integrators, counter and combs hold; valid=0.
- Decimation counter:
  - 3-bit counter cnt, increments on each enabled edge and wraps 7→0.
  - Strobe condition: en=1 and cnt==7.
- Comb section, executed on the strobe edge in a single clock:
  - c0 = i3 (pre-edge value); c1 = c0 − d0; c2 = c1 − d1; c3 = c2 − d2.
  - Delay registers update: d0<=c0, d1<=c1, d2<=c2.
  - dout <= c3[NMAX-1 -: NOUT].
- valid:
  - Goes to 1 on the same edge that updates dout (strobe edge) and returns to 0 on the next edge.
  - Exactly one valid per 8 enabled samples. If en stays high continuously, valid is periodic every 8 clocks.
- Gaps in en stretch the decimation period but do not change results.
- DC gain is R^N = 512, so the full-scale input fits NMAX=21 exactly without output overflow.

Optional Feature:
- Macro: CIC_OUT_ROUND_EN.
- Defined:
  - When NOUT < NMAX, dout = round-half-up of c3 to NOUT bits, i.e. add 1 at bit (NMAX−NOUT−1) before slicing.
  - Saturate at the maximum positive NOUT value if the addition overflows.
- Undefined: plain truncation (MSB slice).
- Either way, NOUT == NMAX gives identical output.

Decomposition:
- Package cic_pkg holds localparams N=3, R=8, M=1, CNT_W=3, and the helper function for the bit-growth width.
- One natural sub-module, cic_integrator: a single NMAX-bit enabled accumulator with synchronous reset, instantiated three times.
- Combs, counter and output stage stay in the top module.

Test Plan:
- Reset: hold rstn=1 for 3 clocks with en=1, din=0x155 → valid=0, dout=0 throughout. After release, the first valid appears exactly 8 enabled clocks later.
- DC small: en=1, din=1 constant → outputs settle within 4 valid pulses. Thereafter dout=512 (0x000200) on every valid, every 8 clocks.
- DC positive full scale: din=0x7FF → steady dout = 2047·512 = 1048064 (0x0FFE00). No overflow; integrators wrap internally.
- DC negative full scale: din=0x800 → steady dout = −1048576 (0x100000).
- en gating: pattern en=1,0,1,0… with din=1 → one valid per 8 enabled samples (every 16 clocks); steady dout=512, identical to the continuous case.
- Tone: 200-point 12-bit cosine table, amplitude ±2047 at 0.15·fs, looped with en=1 for 2000 clocks → 250 valid pulses. dout matches a bit-accurate golden model (N=3, R=8, M=1, truncation). Mid-run reset re-clears all state.
